// File: rtl/addr_encoder_burst.sv
// ============================================================================
// addr_encoder_burst : burst address generator with binary / Gray / bit-reverse
//                      encoding and valid/ready handshakes on both sides.
// Revision 1.0
// ============================================================================
`default_nettype none

module addr_encoder_burst #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [LEN_W-1:0]  in_len,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  beat_q;
  logic [LEN_W-1:0]  len_q;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] out_q;
  logic              last_q;
  logic              valid_q;

  logic [ADDR_W-1:0] addr_d;
  logic [LEN_W-1:0]  beat_d;
  logic              cmd_acc;
  logic              beat_acc;

  function automatic logic [ADDR_W-1:0] enc(input logic [ADDR_W-1:0] a,
                                            input logic [1:0]        m);
    logic [ADDR_W-1:0] b;
    b = a;
    case (m)
      2'd1: b = a ^ (a >> 1);
      2'd2: begin
        for (int i = ADDR_W - 2; i >= 0; i--) begin
          b[i] = b[i+1] ^ a[i];
        end
      end
      2'd3: begin
        for (int i = 0; i < ADDR_W; i++) begin
          b[i] = a[ADDR_W-1-i];
        end
      end
      default: b = a;
    endcase
    return b;
  endfunction

  // The counter is incremented in binary; encoding is applied afterwards.
  assign addr_d   = addr_q + ADDR_W'(1);
  assign beat_d   = beat_q + LEN_W'(1);
  assign beat_acc = valid_q && out_ready;
  assign in_ready = (state_q == IDLE) || (beat_acc && last_q);
  assign cmd_acc  = in_valid && in_ready;

  assign out_valid = valid_q;
  assign out       = out_q;
  assign out_last  = last_q;
  assign busy      = (state_q == BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      mode_q  <= 2'd0;
      out_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (cmd_acc) begin
      // Covers both the IDLE start and the back-to-back reload on the last beat.
      state_q <= BURST;
      addr_q  <= in_addr;
      beat_q  <= '0;
      len_q   <= in_len;
      mode_q  <= mode;
      out_q   <= enc(in_addr, mode);
      last_q  <= (in_len == '0);
      valid_q <= 1'b1;
    end else if (beat_acc) begin
      if (last_q) begin
        state_q <= IDLE;
        last_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        addr_q <= addr_d;
        beat_q <= beat_d;
        out_q  <= enc(addr_d, mode_q);
        last_q <= (beat_d == len_q);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_addr_encoder_burst.sv
// Bench for addr_encoder_burst: directed literal bursts plus randomized traffic
// compared every cycle against a queue-based model of expected beats.
`default_nettype none

module tb_addr_encoder_burst;

  localparam int ADDR_W = 12;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [LEN_W-1:0]  in_len = '0;
  logic [1:0]        mode = 2'd0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] out;
  logic              out_last;
  logic              busy;

  int checks = 0;
  int failures = 0;

  addr_encoder_burst #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_len(in_len), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] v;
    logic              l;
  } beat_t;

  beat_t q[$];
  logic  cmd_taken = 1'b0;

  function automatic logic [ADDR_W-1:0] m_enc(input logic [ADDR_W-1:0] a, input int m);
    logic [ADDR_W-1:0] r;
    r = a;
    if (m == 1) r = a ^ (a >> 1);
    if (m == 2) for (int i = 0; i < ADDR_W; i++) r[i] = ^(a >> i);
    if (m == 3) for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

  function automatic logic exp_ready();
    return (q.size() == 0) || (out_ready && q.size() == 1);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the whole burst is queued on acceptance; a beat leaves on handshake.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cmd_taken = 1'b0;
    end else begin
      logic rdy;
      logic [ADDR_W-1:0] a;
      rdy = exp_ready();
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      cmd_taken = in_valid && rdy;
      if (cmd_taken) begin
        for (int i = 0; i <= int'(in_len); i++) begin
          a = in_addr + ADDR_W'(i);
          q.push_back('{v: m_enc(a, int'(mode)), l: (i == int'(in_len))});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst out_valid", int'(out_valid), 0);
      check("rst out", int'(out), 0);
      check("rst out_last", int'(out_last), 0);
      check("rst busy", int'(busy), 0);
      check("rst in_ready", int'(in_ready), 1);
    end else begin
      check("cmp out_valid", int'(out_valid), int'(q.size() > 0));
      check("cmp busy", int'(busy), int'(q.size() > 0));
      check("cmp in_ready", int'(in_ready), int'(exp_ready()));
      if (q.size() > 0) begin
        check("cmp out", int'(out), int'(q[0].v));
        check("cmp out_last", int'(out_last), int'(q[0].l));
      end
    end
  end

  task automatic wait_acc();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!cmd_taken && n < 50);
    check("accept", int'(cmd_taken), 1);
  endtask

  task automatic issue(input int a, input int l, input int m);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_addr  = ADDR_W'(a);
    in_len   = LEN_W'(l);
    mode     = 2'(m);
    wait_acc();
    in_valid = 1'b0;
  endtask

  task automatic lit(input string nm, input int v, input int l);
    @(negedge clk);
    check({nm, " valid"}, int'(out_valid), 1);
    check({nm, " out"}, int'(out), v);
    check({nm, " last"}, int'(out_last), l);
    check({nm, " busy"}, int'(busy), 1);
  endtask

  task automatic idle_chk(input string nm);
    @(negedge clk);
    check({nm, " valid"}, int'(out_valid), 0);
    check({nm, " busy"}, int'(busy), 0);
    check({nm, " in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    check("model gray 5", int'(m_enc(12'h005, 1)), 12'h007);
    check("model gray 8", int'(m_enc(12'h008, 1)), 12'h00C);
    check("model g2b 7", int'(m_enc(12'h007, 2)), 12'h005);
    check("model rev 1", int'(m_enc(12'h001, 3)), 12'h800);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    issue(12'h005, 3, 1);
    lit("g0", 12'h007, 0);
    lit("g1", 12'h005, 0);
    lit("g2", 12'h004, 0);
    lit("g3", 12'h00C, 1);
    idle_chk("g_end");

    issue(12'hFFE, 2, 0);
    lit("w0", 12'hFFE, 0);
    lit("w1", 12'hFFF, 0);
    lit("w2", 12'h000, 1);
    idle_chk("w_end");

    issue(12'h007, 0, 2);
    lit("g2b", 12'h005, 1);
    issue(12'h001, 0, 3);
    lit("rev", 12'h800, 1);

    @(posedge clk); #1 out_ready = 1'b0;
    issue(12'h100, 1, 0);
    repeat (3) lit("bp hold", 12'h100, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    lit("bp b0", 12'h100, 0);
    lit("bp b1", 12'h101, 1);
    idle_chk("bp_end");

    @(posedge clk); #1;
    in_valid = 1'b1; in_addr = 12'h300; in_len = 4'd1; mode = 2'd0;
    wait_acc();
    in_addr = 12'h200; in_len = 4'd0;
    lit("bb a0", 12'h300, 0);
    lit("bb a1", 12'h301, 1);
    @(posedge clk); #1;
    check("bb accept", int'(cmd_taken), 1);
    in_valid = 1'b0;
    @(negedge clk);
    check("bb b0 out", int'(out), 12'h200);
    check("bb b0 last", int'(out_last), 1);
    check("bb b0 busy", int'(busy), 1);
    idle_chk("bb_end");

    issue(12'h400, 3, 0);
    lit("rm b0", 12'h400, 0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rm valid", int'(out_valid), 0);
    check("rm out", int'(out), 0);
    check("rm last", int'(out_last), 0);
    check("rm busy", int'(busy), 0);
    check("rm in_ready", int'(in_ready), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    issue(12'h0A0, 1, 1);
    lit("post0", 12'h0F0, 0);
    lit("post1", 12'h0F1, 1);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!in_valid || cmd_taken) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_addr  = ($urandom_range(0, 3) == 0) ? ADDR_W'(12'hFF8 + $urandom_range(0, 7))
                                               : ADDR_W'($urandom_range(0, 4095));
        in_len   = LEN_W'($urandom_range(0, 15));
        mode     = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    begin
      int n = 0;
      while (q.size() > 0 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      check("drain", q.size(), 0);
    end
    idle_chk("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/addr_encoder_burst.md
# addr_encoder_burst

Parametrised, registered address encoder with a burst generator and valid/ready handshakes on both sides. It accepts a start address, a beat count and an encoding mode. It then emits one encoded address per handshake, auto-incrementing modulo 2^ADDR_W. It sits between address-generating control logic and memory or bus blocks that expect binary, Gray-coded or bit-reversed addresses.

## Interface
- ADDR_W, 12, address width in bits (≥2)
- LEN_W, 4, burst-length field width; burst = in_len+1 beats (1..2^LEN_W)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  command valid
- in_ready  output  1  command accepted when in_valid && in_ready at clk rise
- in_addr  input  ADDR_W  burst start address (binary)
- in_len  input  LEN_W  beats minus one
- mode  input  2  encoding: 0 binary, 1 binary→Gray, 2 Gray→binary, 3 bit-reverse
- out_valid  output  1  encoded beat valid
- out_ready  input  1  consumer accepts beat when out_valid && out_ready at clk rise
- out  output  ADDR_W  encoded address, registered
- out_last  output  1  marks final beat of burst, registered
- busy  output  1  burst in progress (state BURST)

## Operation
- FSM states: IDLE, BURST.
- IDLE: in_ready=1. On command handshake: latch addr_cnt=in_addr, beat_cnt=0, len_q=in_len, mode_q=mode. Load out=enc(in_addr), out_last=(in_len==0), out_valid=1. Go to BURST.
- BURST: out, out_last and out_valid hold stable while out_valid && !out_ready.
- Beat handshake with out_last=0: addr_cnt+=1 (wraps 2^ADDR_W−1→0), beat_cnt+=1. Load out=enc(addr_cnt+1), out_last=(beat_cnt+1==len_q).
- Beat handshake with out_last=1:
  - in_valid=1: new command accepted in the same cycle (back-to-back). Reload as in IDLE and stay in BURST.
  - in_valid=0: out_valid=0, go to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is a combinational path from out_ready to in_ready. There is no combinational path from any input to out, out_valid or out_last.
- enc(a):
  - mode 0: a.
  - mode 1: a ^ (a>>1).
  - mode 2: b[ADDR_W−1]=a[ADDR_W−1]; b[i]=b[i+1]^a[i].
  - mode 3: b[i]=a[ADDR_W−1−i].
- Arithmetic is unsigned. The increment is applied to the binary counter before encoding, never to the encoded value.
- mode and in_len are sampled only at command acceptance. Changes during a burst are ignored.
- Commands presented while in_ready=0 are not accepted. The source must hold them stable.

## Timing
- Reset (async assert, synchronous deassert by the system): state=IDLE, out_valid=0, out_last=0, out=0, busy=0, in_ready=1 (combinational from IDLE).
- Latency: command at edge k → first beat valid after edge k. No bubbles with out_ready held high: N beats occupy N consecutive cycles.
- Back-to-back bursts with in_valid and out_ready both high: zero idle cycles between the last beat of one burst and the first of the next.
- Reset mid-burst: all outputs return to reset values immediately. The burst is discarded with no partial resume.
- Wrap-around inside a burst is legal, and out_last is determined solely by beat_cnt.

## Test plan
- ADDR_W=12, mode 1, in_addr=0x005, in_len=3, out_ready=1 → out 0x007, 0x005, 0x004, 0x00C on 4 consecutive cycles; out_last only on 0x00C; then IDLE.
- Mode 0, in_addr=0xFFE, in_len=2 → 0xFFE, 0xFFF, 0x000; out_last on 0x000 (wrap).
- Mode 2, in_addr=0x007, in_len=0 → single beat 0x005 with out_last=1. Mode 3, in_addr=0x001, in_len=0 → 0x800.
- Backpressure: mode 0, in_addr=0x100, in_len=1, out_ready low 3 cycles → out holds 0x100 with out_valid=1. On release, 0x100 then 0x101; no beat lost or duplicated.
- Back-to-back: second command (0x200, len 0) held valid during last beat of first burst → accepted on that edge; 0x200 appears the next cycle with busy continuously 1.
- Reset mid-burst: assert rst_n=0 between edges during beat 2 of 4 → out_valid, out, out_last, busy go 0 immediately; after release, in_ready=1 and a new burst runs correctly.
